bus_reduce_pipe: RTL and testbench
==================================

# bus_reduce_pipe

Parametrised, pipelined bus-reduction unit. It accepts `LANES` input words of `WIDTH` bits per beat and combines them bitwise with a runtime-selected operator (AND/OR/XOR). Unwanted lanes can be masked per beat. The reduction tree is registered at every level behind a valid/ready handshake with full back-pressure. It replaces hand-instantiated AND2/OR2 gate netlists on bus nets in the bus-analysis designs.

## Interface
- `WIDTH`, default 4: bits per lane; range 1..64.
- `LANES`, default 4: input lanes; power of two, range 2..16.
- `LEVELS`, derived, equal to clog2(`LANES`): pipeline depth. Not user-overridable.
- `clk`  input  1  sole clock; all flops rising-edge.
- `reset`  input  1  asynchronous, active-high; clears all state.
- `in_valid`  input  1  input beat present.
- `in_ready`  output  1  unit accepts the beat this cycle.
- `in_data`  input  `LANES*WIDTH`  lane k occupies bits [k*WIDTH +: WIDTH].
- `in_mask`  input  `LANES`  1 = lane k replaced by the operator identity.
- `in_mode`  input  2  operator: 0 AND, 1 OR, 2 XOR, 3 reserved.
- `out_valid`  output  1  result present.
- `out_ready`  input  1  downstream accepts the result.
- `out_data`  output  `WIDTH`  reduced word.
- `out_err`  output  1  beat was issued with reserved mode.

## Operation
- **Transfer rule.** A beat transfers when `in_valid && in_ready`. A result transfers when `out_valid && out_ready`.
- **Masking and mode capture (stage 0).** Each masked lane is replaced by the identity: all-ones for AND, zero for OR/XOR. Mode and the error flag travel with the beat through every stage.
- **Tree levels.** Each level combines adjacent pairs, halving the lane count. It is then registered with its own valid bit. The final level register drives `out_data`.
- **Reserved mode.** Mode 3 yields `out_data` = 0 and `out_err` = 1 for that beat only. No other state is affected.
- **All lanes masked.** The result is the identity: 0xF for AND at `WIDTH` 4, 0 for OR/XOR.
- **Stall rule.** A stage loads when its register is empty, or when the next stage (or `out_ready` for the last) consumes its content in the same cycle.
  - `in_ready` = stage-0 load condition. It is combinational from `out_ready` through the chain.
  - No bubbles are inserted.
  - Order is preserved.
  - Data/mode/err registers hold while stalled.
- **Output stability.** While `out_valid` is high and `out_ready` is low, `out_data` and `out_err` must not change.
- **Simultaneous events.** Consume at the output and accept at the input in the same cycle with a full pipe: both occur. Throughput stays 1 beat/cycle.
- **Reset.**
  - On assertion: all valid bits, `out_data` and `out_err` are 0 immediately, independent of `clk`. In-flight beats are discarded.
  - `in_ready` reads 1 whenever the pipe is empty, including during reset. The bench must not drive `in_valid` during reset.

## Timing
- Latency: a beat accepted at edge n appears with `out_valid` = 1 after edge n+`LEVELS`, given no stall. For example, 2 cycles at `LANES` 4 and 4 cycles at `LANES` 16.
- Throughput: 1 beat per cycle sustained while `out_ready` = 1.
- Capacity: `LEVELS` beats in flight. With `out_ready` held low, `in_ready` drops once all `LEVELS` registers are full.
- Reset values:
  - `out_valid` 0
  - `out_data` 0
  - `out_err` 0
  - `in_ready` 1
- Combinational paths:
  - `out_ready` → `in_ready`: yes.
  - Input → output data: none.

## Structure
- Package `bus_reduce_pkg` holds:
  - mode constants `MODE_AND`, `MODE_OR`, `MODE_XOR`, `MODE_RSVD`;
  - function `reduce_identity(mode, width)`;
  - function `reduce_op(mode, a, b)`.
- Sub-module `bus_reduce_stage`, parametrised by `WIDTH` and input lane count. It does one pairwise combine level plus its valid/data/mode/err register and local stall logic.
- The top generates `LEVELS` instances and adds stage-0 masking. Stage-0 masking is combinational, in front of the first stage register.

## Test plan
All scenarios use `WIDTH` 4 and `LANES` 4 unless noted.
1. **AND reduce.** Mode 0, lanes {0xF,0xE,0x7,0xF}, mask 0 → `out_data` 0x6, `out_err` 0, `out_valid` exactly 2 cycles after acceptance.
2. **OR with mask.** Mode 1, lanes {0x1,0x2,0x4,0x8}, mask 4'b0010 → 0xD. Then XOR, same lanes, mask 0 → 0xF. Then AND, mask 4'hF → 0xF.
3. **Streaming.** 8 back-to-back beats with `out_ready` = 1 and random mode 0..2 → 8 consecutive results, each matching the reference model, in order, no gaps.
4. **Back-pressure.**
   - Stimulus: 4 beats offered, `out_ready` low for 5 cycles.
   - `in_ready` falls after 2 beats are accepted.
   - `out_data` stays stable throughout.
   - After `out_ready` rises, all 4 results appear in order with none lost or duplicated.
5. **Reserved mode.** Mode 3 beat between two OR beats → `out_data` 0 and `out_err` 1 on that beat only. Neighbours are correct with `out_err` 0.
6. **Reset mid-flight.** Assert `reset` with 2 beats in flight → `out_valid` 0 without a clock edge. After release, no stale result appears, and a fresh beat completes with latency 2.
7. **Scaled configuration.** `LANES` 16, `WIDTH` 8 → latency 4. All-lanes 0xA5 XOR with mask 0 → 0x00.

Source files
------------

// File: rtl/bus_reduce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_reduce_pkg
// Description : Mode encodings and combine helpers shared by the bus
//               reduction pipeline, its stages and its interface.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_reduce_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_AND  = 2'd0;
  localparam mode_t MODE_OR   = 2'd1;
  localparam mode_t MODE_XOR  = 2'd2;
  localparam mode_t MODE_RSVD = 2'd3;

  // Neutral element of the selected operator, right-aligned in 64 bits.
  // The reserved mode uses zero so that its result collapses to 0.
  function automatic logic [63:0] reduce_identity(input mode_t mode, input int width);
    logic [63:0] v_ones;
    v_ones = {64{1'b1}} >> (64 - width);
    return (mode == MODE_AND) ? v_ones : 64'd0;
  endfunction

  // One pairwise combine. The reserved mode forces a zero result.
  function automatic logic [63:0] reduce_op(input mode_t mode, input logic [63:0] a,
                                            input logic [63:0] b);
    logic [63:0] v_res;
    case (mode)
      MODE_AND: v_res = a & b;
      MODE_OR:  v_res = a | b;
      MODE_XOR: v_res = a ^ b;
      default:  v_res = 64'd0;
    endcase
    return v_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_reduce_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_reduce_pipe_if
// Description : Input beat and output result handshakes of the bus
//               reduction pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_reduce_pipe_if
  import bus_reduce_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LANES = 4
);

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic [LANES-1:0]       in_mask;
  mode_t                  in_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_err;

  // Producer/consumer side, outside the reduction unit.
  modport master (
    output in_valid, in_data, in_mask, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  // The reduction unit itself.
  modport slave (
    input  in_valid, in_data, in_mask, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

endinterface
`default_nettype wire

// File: rtl/bus_reduce_stage.sv
`default_nettype none
// ============================================================================
// Module      : bus_reduce_stage
// Description : One reduction tree level: combines adjacent lane pairs and
//               registers the result with valid/mode/err under a local
//               valid/ready stall rule.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_reduce_stage
  import bus_reduce_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int LANES_IN  = 4,
  localparam int LANES_OUT = LANES_IN / 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES_IN*WIDTH-1:0]  in_data,
  input  mode_t                      in_mode,
  input  logic                       in_err,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES_OUT*WIDTH-1:0] out_data,
  output mode_t                      out_mode,
  output logic                       out_err
);

  logic [LANES_OUT*WIDTH-1:0] w_comb;
  logic                       w_load;

  logic                       r_valid;
  logic [LANES_OUT*WIDTH-1:0] r_data;
  mode_t                      r_mode;
  logic                       r_err;

  for (genvar k = 0; k < LANES_OUT; k++) begin : g_pair
    assign w_comb[k*WIDTH +: WIDTH] = WIDTH'(reduce_op(in_mode,
                                        64'(in_data[(2*k)*WIDTH +: WIDTH]),
                                        64'(in_data[(2*k+1)*WIDTH +: WIDTH])));
  end

  // Load when empty or when the downstream side drains us this cycle.
  assign w_load   = ~r_valid | out_ready;
  assign in_ready = w_load;

  // Level register: payload only changes on an actual transfer, so it holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mode  <= MODE_AND;
      r_err   <= 1'b0;
    end else if (w_load) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data <= w_comb;
        r_mode <= in_mode;
        r_err  <= in_err;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_mode  = r_mode;
  assign out_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/bus_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bus_reduce_pipe
// Description : Pipelined bitwise AND/OR/XOR reduction of LANES words with
//               per-beat lane masking and full back-pressure; one register
//               per tree level.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_reduce_pipe
  import bus_reduce_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             reset,
  bus_reduce_pipe_if.slave bus
);

  localparam int LEVELS = $clog2(LANES);

  logic [WIDTH-1:0]       w_ident;
  logic [LANES*WIDTH-1:0] w_masked;
  logic                   w_rsvd;

  // Masked lanes become the operator identity, so they drop out of the reduction.
  assign w_ident = WIDTH'(reduce_identity(bus.in_mode, WIDTH));
  assign w_rsvd  = (bus.in_mode == MODE_RSVD);

  for (genvar k = 0; k < LANES; k++) begin : g_mask
    assign w_masked[k*WIDTH +: WIDTH] = bus.in_mask[k] ? w_ident : bus.in_data[k*WIDTH +: WIDTH];
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int LIN = LANES >> l;

    logic                     w_in_valid;
    logic [LIN*WIDTH-1:0]     w_in_data;
    mode_t                    w_in_mode;
    logic                     w_in_err;
    logic                     w_up_ready;
    logic                     w_down_ready;
    logic                     w_out_valid;
    logic [(LIN/2)*WIDTH-1:0] w_out_data;
    mode_t                    w_out_mode;
    logic                     w_out_err;

    if (l == 0) begin : g_first
      assign w_in_valid = bus.in_valid;
      assign w_in_data  = w_masked;
      assign w_in_mode  = bus.in_mode;
      assign w_in_err   = w_rsvd;
    end else begin : g_chain
      assign w_in_valid = g_level[l-1].w_out_valid;
      assign w_in_data  = g_level[l-1].w_out_data;
      assign w_in_mode  = g_level[l-1].w_out_mode;
      assign w_in_err   = g_level[l-1].w_out_err;
    end

    // Ready ripples back combinationally from out_ready through every level.
    if (l == LEVELS - 1) begin : g_last
      assign w_down_ready = bus.out_ready;
    end else begin : g_mid
      assign w_down_ready = g_level[l+1].w_up_ready;
    end

    bus_reduce_stage #(
      .WIDTH    (WIDTH),
      .LANES_IN (LIN)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (w_in_valid),
      .in_ready  (w_up_ready),
      .in_data   (w_in_data),
      .in_mode   (w_in_mode),
      .in_err    (w_in_err),
      .out_valid (w_out_valid),
      .out_ready (w_down_ready),
      .out_data  (w_out_data),
      .out_mode  (w_out_mode),
      .out_err   (w_out_err)
    );
  end

  assign bus.in_ready  = g_level[0].w_up_ready;
  assign bus.out_valid = g_level[LEVELS-1].w_out_valid;
  assign bus.out_data  = g_level[LEVELS-1].w_out_data;
  assign bus.out_err   = g_level[LEVELS-1].w_out_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_reduce_pipe
// Description : Self-checking bench for bus_reduce_pipe (4x4 and 16x8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_reduce_pipe;
  import bus_reduce_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bus_reduce_pipe_if #(.WIDTH(4), .LANES(4))  ifc4 ();
  bus_reduce_pipe_if #(.WIDTH(8), .LANES(16)) ifc16 ();

  bus_reduce_pipe #(.WIDTH(4), .LANES(4))  dut4  (.clk(clk), .reset(reset), .bus(ifc4));
  bus_reduce_pipe #(.WIDTH(8), .LANES(16)) dut16 (.clk(clk), .reset(reset), .bus(ifc16));

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  mask;
    logic [15:0] data;
    logic [3:0]  exp;
    logic        err;
  } vec_t;

  vec_t vecs [11];

  logic [1:0]  s_mode [16];
  logic [3:0]  s_mask [16];
  logic [15:0] s_data [16];
  logic [3:0]  s_exp  [16];
  logic        s_err  [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] model(input logic [1:0] m, input logic [3:0] mk,
                                       input logic [15:0] d);
    logic [3:0] acc;
    logic [3:0] lane;
    if (m == 2'd3) return 4'h0;
    acc = (m == 2'd0) ? 4'hF : 4'h0;
    for (int k = 0; k < 4; k++) begin
      lane = d[k*4 +: 4];
      if (!mk[k]) begin
        case (m)
          2'd0:    acc = acc & lane;
          2'd1:    acc = acc | lane;
          default: acc = acc ^ lane;
        endcase
      end
    end
    return acc;
  endfunction

  // Single beat on the 4x4 unit with out_ready high; checks latency, data, err.
  task automatic run_vec(input string name, input logic [1:0] mode, input logic [3:0] mask,
                         input logic [15:0] data, input logic [3:0] exp, input logic err);
    logic ok;
    int   tries;
    int   lat;
    @(posedge clk); #1;
    ifc4.in_valid = 1'b1;
    ifc4.in_mode  = mode;
    ifc4.in_mask  = mask;
    ifc4.in_data  = data;
    tries = 0;
    do begin
      @(negedge clk);
      ok = ifc4.in_ready;
      @(posedge clk);
      tries++;
    end while (!ok && tries < 20);
    check({name, " accept"}, 64'(ok), 64'd1);
    #1 ifc4.in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (ifc4.out_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'd2);
    check({name, " data"}, 64'(ifc4.out_data), 64'(exp));
    check({name, " err"}, 64'(ifc4.out_err), 64'(err));
  endtask

  // Back-to-back beats from the s_* arrays with out_ready high.
  task automatic stream_run(input string name, input int n);
    for (int c = 0; c < n + 3; c++) begin
      @(posedge clk); #1;
      if (c < n) begin
        ifc4.in_valid = 1'b1;
        ifc4.in_mode  = s_mode[c];
        ifc4.in_mask  = s_mask[c];
        ifc4.in_data  = s_data[c];
      end else begin
        ifc4.in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < n) check($sformatf("%s in_ready %0d", name, c), 64'(ifc4.in_ready), 64'd1);
      if (c >= 2 && c - 2 < n) begin
        check($sformatf("%s valid %0d", name, c - 2), 64'(ifc4.out_valid), 64'd1);
        check($sformatf("%s data %0d", name, c - 2), 64'(ifc4.out_data), 64'(s_exp[c-2]));
        check($sformatf("%s err %0d", name, c - 2), 64'(ifc4.out_err), 64'(s_err[c-2]));
      end else begin
        check($sformatf("%s idle %0d", name, c), 64'(ifc4.out_valid), 64'd0);
      end
    end
  endtask

  // Single beat on the 16x8 unit; latency is four levels.
  task automatic run16(input string name, input logic [1:0] mode, input logic [15:0] mask,
                       input logic [127:0] data, input logic [7:0] exp);
    logic ok;
    int   tries;
    int   lat;
    @(posedge clk); #1;
    ifc16.in_valid = 1'b1;
    ifc16.in_mode  = mode;
    ifc16.in_mask  = mask;
    ifc16.in_data  = data;
    tries = 0;
    do begin
      @(negedge clk);
      ok = ifc16.in_ready;
      @(posedge clk);
      tries++;
    end while (!ok && tries < 20);
    check({name, " accept"}, 64'(ok), 64'd1);
    #1 ifc16.in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (ifc16.out_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'd4);
    check({name, " data"}, 64'(ifc16.out_data), 64'(exp));
    check({name, " err"}, 64'(ifc16.out_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bi;
    int ri;
    bit drop_seen;

    // lane 0 is the least significant nibble of data
    vecs[0]  = '{2'd0, 4'b0000, 16'hF7EF, 4'h6, 1'b0};
    vecs[1]  = '{2'd1, 4'b0010, 16'h8421, 4'hD, 1'b0};
    vecs[2]  = '{2'd2, 4'b0000, 16'h8421, 4'hF, 1'b0};
    vecs[3]  = '{2'd0, 4'b1111, 16'h8421, 4'hF, 1'b0};
    vecs[4]  = '{2'd2, 4'b1111, 16'hFFFF, 4'h0, 1'b0};
    vecs[5]  = '{2'd1, 4'b0000, 16'h8421, 4'hF, 1'b0};
    vecs[6]  = '{2'd3, 4'b0000, 16'hFFFF, 4'h0, 1'b1};
    vecs[7]  = '{2'd0, 4'b0000, 16'hFFFF, 4'hF, 1'b0};
    vecs[8]  = '{2'd2, 4'b0000, 16'h1234, 4'h4, 1'b0};
    vecs[9]  = '{2'd1, 4'b0000, 16'h0000, 4'h0, 1'b0};
    vecs[10] = '{2'd0, 4'b0001, 16'h7EF5, 4'h6, 1'b0};

    reset = 1'b1;
    ifc4.in_valid = 1'b0;  ifc4.in_mode = 2'd0;  ifc4.in_mask = '0;  ifc4.in_data = '0;
    ifc4.out_ready = 1'b1;
    ifc16.in_valid = 1'b0; ifc16.in_mode = 2'd0; ifc16.in_mask = '0; ifc16.in_data = '0;
    ifc16.out_ready = 1'b1;

    #2;
    check("reset out_valid", 64'(ifc4.out_valid), 64'd0);
    check("reset out_data", 64'(ifc4.out_data), 64'd0);
    check("reset out_err", 64'(ifc4.out_err), 64'd0);
    check("reset in_ready", 64'(ifc4.in_ready), 64'd1);
    check("reset16 out_valid", 64'(ifc16.out_valid), 64'd0);
    check("reset16 in_ready", 64'(ifc16.in_ready), 64'd1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 11; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].mode, vecs[i].mask, vecs[i].data,
              vecs[i].exp, vecs[i].err);

    // streaming: random modes 0..2
    for (int i = 0; i < 8; i++) begin
      s_mode[i] = 2'($urandom_range(0, 2));
      s_mask[i] = 4'($urandom_range(0, 15));
      s_data[i] = 16'($urandom);
      s_exp[i]  = model(s_mode[i], s_mask[i], s_data[i]);
      s_err[i]  = 1'b0;
    end
    stream_run("stream", 8);

    // reserved mode sandwiched between OR beats
    s_mode[0] = 2'd1; s_mask[0] = 4'b0000; s_data[0] = 16'h0421; s_exp[0] = 4'h7; s_err[0] = 1'b0;
    s_mode[1] = 2'd3; s_mask[1] = 4'b0000; s_data[1] = 16'hFFFF; s_exp[1] = 4'h0; s_err[1] = 1'b1;
    s_mode[2] = 2'd1; s_mask[2] = 4'b0000; s_data[2] = 16'h8000; s_exp[2] = 4'h8; s_err[2] = 1'b0;
    stream_run("rsvd", 3);

    // back-pressure: out_ready low for the first 5 cycles
    s_mode[0] = 2'd0; s_mask[0] = 4'b0000; s_data[0] = 16'hFFFF; s_exp[0] = 4'hF;
    s_mode[1] = 2'd1; s_mask[1] = 4'b0000; s_data[1] = 16'h0102; s_exp[1] = 4'h3;
    s_mode[2] = 2'd2; s_mask[2] = 4'b0000; s_data[2] = 16'h1111; s_exp[2] = 4'h0;
    s_mode[3] = 2'd1; s_mask[3] = 4'b0000; s_data[3] = 16'h8000; s_exp[3] = 4'h8;
    bi = 0; ri = 0; drop_seen = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(posedge clk); #1;
      ifc4.out_ready = (cyc >= 5);
      if (bi < 4) begin
        ifc4.in_valid = 1'b1;
        ifc4.in_mode  = s_mode[bi];
        ifc4.in_mask  = s_mask[bi];
        ifc4.in_data  = s_data[bi];
      end else begin
        ifc4.in_valid = 1'b0;
      end
      @(negedge clk);
      if (ifc4.in_valid && !ifc4.in_ready && !drop_seen) begin
        drop_seen = 1'b1;
        check("bp in_ready drop after beats", 64'(bi), 64'd2);
      end
      if (ifc4.out_valid) begin
        if (ri < 4) check($sformatf("bp data %0d cyc %0d", ri, cyc), 64'(ifc4.out_data),
                          64'(s_exp[ri]));
        else check("bp extra result", 64'(ifc4.out_valid), 64'd0);
        if (ifc4.out_ready) ri++;
      end
      if (ifc4.in_valid && ifc4.in_ready) bi++;
    end
    check("bp in_ready dropped", 64'(drop_seen), 64'd1);
    check("bp accepted", 64'(bi), 64'd4);
    check("bp results", 64'(ri), 64'd4);
    ifc4.out_ready = 1'b1;
    ifc4.in_valid  = 1'b0;

    // reset with two beats in flight
    @(posedge clk); #1;
    ifc4.out_ready = 1'b0;
    ifc4.in_valid = 1'b1; ifc4.in_mode = 2'd1; ifc4.in_mask = 4'b0000; ifc4.in_data = 16'h000F;
    @(posedge clk); #1;
    ifc4.in_mode = 2'd3; ifc4.in_data = 16'h1234;
    @(posedge clk); #1;
    ifc4.in_valid = 1'b0;
    #2;
    check("flight out_valid", 64'(ifc4.out_valid), 64'd1);
    check("flight out_data", 64'(ifc4.out_data), 64'hF);
    reset = 1'b1;
    #1;
    check("async reset out_valid", 64'(ifc4.out_valid), 64'd0);
    check("async reset out_data", 64'(ifc4.out_data), 64'd0);
    check("async reset out_err", 64'(ifc4.out_err), 64'd0);
    check("async reset in_ready", 64'(ifc4.in_ready), 64'd1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    ifc4.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post reset stale %0d", c), 64'(ifc4.out_valid), 64'd0);
    end
    run_vec("fresh", 2'd2, 4'b0000, 16'h0F0A, 4'h5, 1'b0);

    // scaled configuration
    run16("w8l16 xor", 2'd2, 16'h0000, {16{8'hA5}}, 8'h00);
    run16("w8l16 xor mask", 2'd2, 16'h0001, {16{8'hA5}}, 8'hA5);
    run16("w8l16 and", 2'd0, 16'h0000, {{15{8'hFF}}, 8'h3C}, 8'h3C);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
